// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris_pkg
// Description : Shared tetromino types and widths for the piece pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    localparam int PIECE_W    = 3;
    localparam int NUM_PIECES = 7;

    typedef enum logic [PIECE_W-1:0] {
        I          = 3'd0,
        O          = 3'd1,
        T          = 3'd2,
        S          = 3'd3,
        Z          = 3'd4,
        J          = 3'd5,
        L          = 3'd6,
        PIECE_NONE = 3'd7
    } piece_t;

    function automatic logic is_piece(input logic [PIECE_W-1:0] v);
        return v != PIECE_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piece_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : piece_queue_if
// Description : LFSR sample / pop inputs and head / preview outputs of the queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface piece_queue_if #(
    parameter int DEPTH = 4
);
    import tetris_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PIECE_W-1:0]           lfsr_i;
    logic                         take_i;
    logic [PIECE_W-1:0]           piece_o;
    logic                         piece_valid_o;
    logic [PIECE_W*(DEPTH-1)-1:0] preview_o;
    logic [CNT_W-1:0]             count_o;

    modport master (
        output lfsr_i, take_i,
        input  piece_o, piece_valid_o, preview_o, count_o
    );

    modport slave (
        input  lfsr_i, take_i,
        output piece_o, piece_valid_o, preview_o, count_o
    );

endinterface
`default_nettype wire

// File: rtl/piece_fifo.sv
`default_nettype none
// ============================================================================
// Module      : piece_fifo
// Description : Circular piece buffer with registered head and preview taps.
// Revision    : 1.0 - initial release
// ============================================================================
module piece_fifo
    import tetris_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  wire logic                         clk,
    input  wire logic                         reset,
    input  wire logic                         push,
    input  wire logic [PIECE_W-1:0]           push_data,
    input  wire logic                         pop,
    output logic      [PIECE_W-1:0]           head,
    output logic                              head_valid,
    output logic      [PIECE_W*(DEPTH-1)-1:0] preview,
    output logic      [CNT_W-1:0]             count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PIECE_W-1:0]           mem   [DEPTH];
    logic [PIECE_W-1:0]           mem_n [DEPTH];
    logic [PTR_W-1:0]             rd_ptr, wr_ptr, rd_n, wr_n;
    logic [CNT_W-1:0]             count_n;
    logic [PIECE_W-1:0]           head_n;
    logic [PIECE_W*(DEPTH-1)-1:0] preview_n;
    logic                         do_pop, do_push;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    // Taps are computed from next state so head/preview are true flops.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count < CNT_W'(DEPTH)) || do_pop);
        mem_n   = mem;
        rd_n    = rd_ptr;
        wr_n    = wr_ptr;
        if (do_push) begin
            mem_n[wr_ptr] = push_data;
            wr_n          = ptr_add(wr_ptr, 1);
        end
        if (do_pop) rd_n = ptr_add(rd_ptr, 1);
        count_n   = count + CNT_W'(do_push) - CNT_W'(do_pop);
        head_n    = (count_n != '0) ? mem_n[rd_n] : '0;
        preview_n = '0;
        for (int k = 1; k < DEPTH; k++) begin
            if (CNT_W'(k) < count_n)
                preview_n[PIECE_W*(k-1) +: PIECE_W] = mem_n[ptr_add(rd_n, k)];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head       <= '0;
            head_valid <= 1'b0;
            preview    <= '0;
        end else begin
            mem        <= mem_n;
            rd_ptr     <= rd_n;
            wr_ptr     <= wr_n;
            count      <= count_n;
            head       <= head_n;
            head_valid <= (count_n != '0);
            preview    <= preview_n;
        end
    end

endmodule
`default_nettype wire

// File: rtl/piece_queue.sv
`default_nettype none
// ============================================================================
// Module      : piece_queue
// Description : Filters raw LFSR samples into de-duplicated pieces and queues them.
// Revision    : 1.0 - initial release
// ============================================================================
module piece_queue
    import tetris_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int REROLLS = 2
) (
    input  wire logic     clk,
    input  wire logic     reset,
    piece_queue_if.slave  q
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RR_W  = (REROLLS < 1) ? 1 : $clog2(REROLLS + 1);

    piece_t            last_accepted;
    logic [RR_W-1:0]   reroll_cnt;
    logic              push_en, is_valid, is_dup, accept, reject;

    always_comb begin
        push_en  = (q.count_o < CNT_W'(DEPTH)) || (q.take_i && q.piece_valid_o);
        is_valid = is_piece(q.lfsr_i);
        is_dup   = (q.lfsr_i == last_accepted) && (reroll_cnt < RR_W'(REROLLS));
        accept   = push_en && is_valid && !is_dup;
        reject   = push_en && is_valid && is_dup;
    end

    // Filter state only moves on cycles where a sample is actually evaluated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_accepted <= PIECE_NONE;
            reroll_cnt    <= '0;
        end else if (accept) begin
            last_accepted <= piece_t'(q.lfsr_i);
            reroll_cnt    <= '0;
        end else if (reject) begin
            reroll_cnt    <= reroll_cnt + RR_W'(1);
        end
    end

    piece_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_data  (q.lfsr_i),
        .pop        (q.take_i),
        .head       (q.piece_o),
        .head_valid (q.piece_valid_o),
        .preview    (q.preview_o),
        .count      (q.count_o)
    );

endmodule
`default_nettype wire

// File: doc/piece_queue.md
Name: piece_queue

Overview:
Downstream consumer of the 3-bit free-running piece LFSR. Turns raw LFSR samples into a validated, de-duplicated stream of tetromino IDs (0..6). Holds them in a small preview FIFO. The game controller pops the head when spawning a piece; the HUD reads the following entries as "next piece" previews.

Parameters:
DEPTH, 4, total queue entries (head + DEPTH-1 previews); legal range 2..8
REROLLS, 2, max consecutive rejections of a sample equal to the last accepted piece before it is accepted anyway; 0 disables de-dup

Ports:
clk  input  1  clock; the LFSR runs on the same clock
reset  input  1  reset, asynchronous, active-high
lfsr_i  input  3  raw LFSR value, sampled every cycle
take_i  input  1  consumer pops the head this cycle
piece_o  output  3  head piece ID, registered; 0 when empty
piece_valid_o  output  1  head is valid
preview_o  output  3*(DEPTH-1)  entries 1..DEPTH-1; slice [2:0] = entry 1; unfilled slots read 0
count_o  output  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Reset (async, any time including mid-fill or mid-pop):
  - Queue empty, count_o=0, piece_valid_o=0, piece_o=0, preview_o=0.
  - last_accepted=7 (none), reroll_cnt=0.
- Push-enable: push_en = (count < DEPTH) || (take_i && piece_valid_o).
  - When full with a simultaneous pop, push still happens and count is unchanged.
- Candidate evaluation, each cycle push_en=1, on lfsr_i:
  - lfsr_i==7: invalid. No push; reroll_cnt unchanged.
  - lfsr_i==last_accepted and reroll_cnt<REROLLS: reject. No push; reroll_cnt++.
  - Otherwise: accept. Push lfsr_i at the tail, last_accepted<=lfsr_i, reroll_cnt<=0.
- When push_en=0, no evaluation occurs; reroll_cnt and last_accepted hold.
- Latency: an accepted sample is visible in count_o at the next edge. piece_o/piece_valid_o update at the same edge if the queue was empty.
- Pop: take_i && piece_valid_o removes the head at the edge; the next entry becomes head in the same edge.
  - take_i while empty is ignored; no underflow and no state change.
- Simultaneous pop + push with count==1: the pushed piece becomes the head; count stays 1.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH or goes below 0.
- Ordering is strict FIFO. Preview entries shift toward the head on every pop.

Decomposition:
- tetris_pkg holds:
  - piece_t: 3-bit enum I=0, O=1, T=2, S=3, Z=4, J=5, L=6, PIECE_NONE=7.
  - PIECE_W=3 and NUM_PIECES=7.
- Sub-module piece_fifo: circular buffer with push/pop, count, and registered head plus preview taps, parameterised by DEPTH.
- piece_queue top contains the validation/reroll filter and push_en logic.

Test Plan:
- Real LFSR instance with shared reset, take_i=0, DEPTH=4. LFSR sequence 1,3,6,5,2,4,0 repeating. After reset release:
  - first edge: piece_o=1, valid=1, count=1;
  - after 4 edges: head=1, preview={3,6,5}, count=4;
  - then frozen.
- From full state [1,3,6,5], pulse take_i for 1 cycle with the LFSR currently at 2 → head=3, preview={6,5,2}, count=4.
- Bench-driven lfsr_i=2 held constant, REROLLS=2, empty queue, take_i=0:
  - 2 pushed at edge 1;
  - edges 2–3 rejected (count stays 1);
  - 2 pushed again at edge 4;
  - after edge 4 reroll_cnt=0; edges 5–6 rejected again.
- Bench-driven lfsr_i=7 for 10 cycles from empty → count_o=0, valid=0 throughout. Then lfsr_i=4 → push at next edge.
- take_i=1 while empty for 3 cycles with lfsr_i=7 → count_o stays 0, no X on outputs.
- Assert reset mid-fill at count=2 (asynchronously, between edges) → all outputs 0 immediately. After release, refill starts with last_accepted=7, so a first sample of 0 is accepted at once.
